// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage of the pipelined Otter core. Owns the program
// counter and fetches 32-bit instructions over a single-outstanding
// request/acknowledge memory handshake. Fetched words go into a 2-entry FIFO
// whose head is presented to decode together with its PC and PC+4. A redirect
// from execute empties the FIFO, restarts fetch at the new target, and
// discards any response still in flight.
//
// Ports
//   FE_CLK       in   1   stage clock, rising edge
//   FE_RST       in   1   asynchronous active-high reset
//   IMEM_REQ     out  1   fetch request, held until acknowledged
//   IMEM_ADDR    out  32  fetch address, stable while IMEM_REQ is high
//   IMEM_ACK     in   1   request completes this cycle
//   IMEM_RDATA   in   32  instruction word, valid with IMEM_ACK
//   STALL        in   1   decode is not accepting this cycle
//   REDIRECT     in   1   flush and restart fetch at REDIRECT_PC
//   REDIRECT_PC  in   32  redirect target, bits [1:0] ignored
//   IR_VALID     out  1   queue head valid
//   IR           out  32  queue-head instruction
//   PC_OUT       out  32  PC of IR
//   PC_PLUS4     out  32  PC_OUT + 4, modulo 2^32
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        FE_CLK,
  input  logic        FE_RST,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_ACK,
  input  logic [31:0] IMEM_RDATA,
  input  logic        STALL,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  output logic        IR_VALID,
  output logic [31:0] IR,
  output logic [31:0] PC_OUT,
  output logic [31:0] PC_PLUS4
);

  // IDLE: no request outstanding. BUSY: request outstanding, response wanted.
  // DRAIN: request outstanding, response will be discarded (redirected).
  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

  localparam logic [1:0] FULL = 2'(BUF_DEPTH);

  state_t      state;
  logic [31:0] fetch_pc;
  logic [31:0] req_pc;
  logic [31:0] q_pc    [2];
  logic [31:0] q_instr [2];
  logic [1:0]  count;

  logic        issue;
  logic        pop;
  logic        push;
  logic [31:0] push_pc;
  logic        wr_idx;

  // Target alignment drops the two low bits of the redirect address.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^REDIRECT_PC[1:0];

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    issue   = (state == IDLE) && (count < FULL) && !REDIRECT;
    pop     = (count != 2'd0) && !STALL;
    push    = 1'b0;
    push_pc = req_pc;
    case (state)
      IDLE: begin
        if (issue && IMEM_ACK) begin
          push    = 1'b1;
          push_pc = fetch_pc;
        end
      end
      BUSY: begin
        if (IMEM_ACK && !REDIRECT) begin
          push    = 1'b1;
          push_pc = req_pc;
        end
      end
      default: ;
    endcase
    // Slot the incoming word lands in, after any same-cycle pop has shifted
    // the queue down by one.
    wr_idx = count[1] | (count[0] & !pop);
  end

  // The request is combinational so a zero-wait memory can complete in the
  // same cycle it is issued, giving one instruction per cycle.
  assign IMEM_REQ  = !FE_RST && (issue || (state != IDLE));
  assign IMEM_ADDR = (state == IDLE) ? fetch_pc : req_pc;

  // Decode-facing outputs come straight from queue registers.
  assign IR_VALID = (count != 2'd0);
  assign IR       = q_instr[0];
  assign PC_OUT   = q_pc[0];
  assign PC_PLUS4 = q_pc[0] + 32'd4;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register here samples the pre-edge values of the others.
  always_ff @(posedge FE_CLK or posedge FE_RST) begin
    if (FE_RST) begin
      state    <= IDLE;
      fetch_pc <= RESET_VEC;
      req_pc   <= 32'd0;
      count    <= 2'd0;
      // NOTE: the queue storage is reset as well because IR and PC_OUT are
      // visible outputs with defined reset values, not just don't-care data.
      for (int i = 0; i < 2; i++) begin
        q_pc[i]    <= 32'd0;
        q_instr[i] <= 32'd0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (issue) begin
            req_pc <= fetch_pc;
            if (!IMEM_ACK) state <= BUSY;
          end
        end
        BUSY: begin
          if (IMEM_ACK)      state <= IDLE;
          else if (REDIRECT) state <= DRAIN;
        end
        DRAIN: begin
          if (IMEM_ACK) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (REDIRECT)  fetch_pc <= {REDIRECT_PC[31:2], 2'b00};
      else if (push) fetch_pc <= fetch_pc + 32'd4;

      // A redirect empties the queue and overrides any push or pop.
      if (REDIRECT) begin
        count <= 2'd0;
      end else begin
        if (pop) begin
          q_pc[0]    <= q_pc[1];
          q_instr[0] <= q_instr[1];
        end
        if (push) begin
          q_pc[wr_idx]    <= push_pc;
          q_instr[wr_idx] <= IMEM_RDATA;
        end
        count <= count + {1'b0, push} - {1'b0, pop};
      end
    end
  end

endmodule
